bht: RTL and testbench

BHT -- requirements
Module: bht

---
 rtl/ariane_pkg.sv | 23 ++
 rtl/bht.sv | 87 ++++++++
 tb/tb_bht.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core types: branch-resolution update from EX and the fetch-side prediction record.
package ariane_pkg;

    localparam int unsigned BHT_ENTRIES = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        logic        valid;
        logic        clear;
        logic        is_lower_16;
    } branchpredict;

    typedef struct packed {
        logic        valid;
        logic        predict_taken;
        logic [63:0] predict_address;
        logic        is_lower_16;
    } branchpredict_sbe;

endpackage

// File: rtl/bht.sv
// Tagless branch history table: 2-bit saturating counters plus a target per entry,
// looked up combinationally by fetch PC and trained by resolved branches.
module bht
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = BHT_ENTRIES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [63:0]      vpc_i,
    input  branchpredict     branchpredict_i,
    output branchpredict_sbe branchpredict_sbe_o
);

    localparam int unsigned IDX = $clog2(NR_ENTRIES);

    logic        valid_q  [NR_ENTRIES];
    logic [1:0]  cnt_q    [NR_ENTRIES];
    logic [63:0] target_q [NR_ENTRIES];
    logic        lower_q  [NR_ENTRIES];

    logic [IDX-1:0] lookup_idx;
    logic [IDX-1:0] update_idx;

    assign lookup_idx = vpc_i[IDX+1:2];
    assign update_idx = branchpredict_i.pc[IDX+1:2];

    // PC bits outside the index and the mispredict flag play no part in prediction.
    logic unused;
    assign unused = ^{vpc_i[63:IDX+2], vpc_i[1:0],
                      branchpredict_i.pc[63:IDX+2], branchpredict_i.pc[1:0],
                      branchpredict_i.is_mispredict};

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != 2'b11) nxt = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

    always_comb begin
        branchpredict_sbe_o = '0;
        if (valid_q[lookup_idx]) begin
            branchpredict_sbe_o.valid           = 1'b1;
            branchpredict_sbe_o.predict_taken   = cnt_q[lookup_idx][1];
            branchpredict_sbe_o.predict_address = target_q[lookup_idx];
            branchpredict_sbe_o.is_lower_16     = lower_q[lookup_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                cnt_q[i]    <= 2'b00;
                target_q[i] <= '0;
                lower_q[i]  <= 1'b0;
            end
        end else if (flush_i) begin
            // Flush drops predictions but keeps targets; they are unreachable until retrained.
            for (int i = 0; i < NR_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b00;
            end
        end else if (branchpredict_i.valid) begin
            if (branchpredict_i.clear) begin
                valid_q[update_idx] <= 1'b0;
                cnt_q[update_idx]   <= 2'b00;
            end else begin
                valid_q[update_idx] <= 1'b1;
                lower_q[update_idx] <= branchpredict_i.is_lower_16;
                if (branchpredict_i.is_taken)
                    target_q[update_idx] <= branchpredict_i.target_address;
                if (!valid_q[update_idx])
                    cnt_q[update_idx] <= branchpredict_i.is_taken ? 2'b10 : 2'b01;
                else
                    cnt_q[update_idx] <= sat_step(cnt_q[update_idx], branchpredict_i.is_taken);
            end
        end
    end

endmodule

// File: tb/tb_bht.sv
// Scenario bench for bht: expected predictions are queued when stimulus is applied
// and drained against the lookup port afterwards.
module tb_bht;
    import ariane_pkg::*;

    typedef struct {
        string            tag;
        logic [63:0]      vpc;
        branchpredict_sbe exp;
    } item_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [63:0]      vpc;
    branchpredict     bp;
    branchpredict_sbe sbe;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    bht #(.NR_ENTRIES(64)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .vpc_i               (vpc),
        .branchpredict_i     (bp),
        .branchpredict_sbe_o (sbe)
    );

    always #5 clk = ~clk;

    function automatic branchpredict_sbe mk(input logic v, input logic t,
                                            input logic [63:0] a, input logic l);
        branchpredict_sbe s;
        s.valid = v; s.predict_taken = t; s.predict_address = a; s.is_lower_16 = l;
        return s;
    endfunction

    function automatic item_t it(input string tag, input logic [63:0] v, input branchpredict_sbe e);
        item_t x;
        x.tag = tag; x.vpc = v; x.exp = e;
        return x;
    endfunction

    task automatic set_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                              input logic l16, input logic clr);
        bp.valid          = 1'b1;
        bp.pc             = pc;
        bp.target_address = tgt;
        bp.is_taken       = taken;
        bp.is_lower_16    = l16;
        bp.clear          = clr;
        bp.is_mispredict  = $urandom_range(0, 1);
    endtask

    task automatic apply_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                                input logic l16, input logic clr);
        @(negedge clk);
        set_update(pc, tgt, taken, l16, clr);
        @(posedge clk);
        #1;
        bp.valid = 1'b0;
    endtask

    task automatic test_reset;
        item_t x;
        rst = 1'b1; flush = 1'b0; vpc = 64'h80; bp = '0;
        #2;
        q.push_back(it("reset_during", 64'h80, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        q.push_back(it("reset_after_80", 64'h80, mk(0, 0, 0, 0)));
        q.push_back(it("reset_after_0", 64'h0, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    task automatic test_train_alias;
        item_t x;
        apply_update(64'h100, 64'h200, 1'b1, 1'b1, 1'b0);
        q.push_back(it("train_hit", 64'h100, mk(1, 1, 64'h200, 1)));
        q.push_back(it("train_alias", 64'h300, mk(1, 1, 64'h200, 1)));
        q.push_back(it("train_other_idx", 64'h104, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    task automatic test_not_taken;
        item_t x;
        // Not-taken updates carry a junk target that must not be stored.
        for (int n = 0; n < 3; n++) begin
            apply_update(64'h100, 64'hDEAD, 1'b0, 1'b0, 1'b0);
            q.push_back(it($sformatf("not_taken_%0d", n), 64'h100, mk(1, 0, 64'h200, 0)));
            while (q.size() > 0) begin
                x = q.pop_front(); vpc = x.vpc; #1; checks++;
                if (sbe !== x.exp) begin
                    errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
                end
            end
        end
        // From 00: one taken -> 01 (not taken), second -> 10 (taken).
        apply_update(64'h100, 64'h240, 1'b1, 1'b1, 1'b0);
        q.push_back(it("recover_01", 64'h100, mk(1, 0, 64'h240, 1)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        apply_update(64'h100, 64'h240, 1'b1, 1'b1, 1'b0);
        q.push_back(it("recover_10", 64'h100, mk(1, 1, 64'h240, 1)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    task automatic test_saturation;
        item_t x;
        for (int n = 0; n < 3; n++) apply_update(64'h10C, 64'h800, 1'b1, 1'b0, 1'b0);
        apply_update(64'h10C, 64'h0, 1'b0, 1'b0, 1'b0);
        q.push_back(it("sat_hi_then_nt", 64'h10C, mk(1, 1, 64'h800, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        apply_update(64'h10C, 64'h0, 1'b0, 1'b1, 1'b0);
        q.push_back(it("sat_second_nt", 64'h10C, mk(1, 0, 64'h800, 1)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    task automatic test_same_cycle;
        item_t x;
        @(negedge clk);
        set_update(64'h104, 64'h400, 1'b1, 1'b0, 1'b0);
        q.push_back(it("same_cycle_no_bypass", 64'h104, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        @(posedge clk);
        #1;
        bp.valid = 1'b0;
        q.push_back(it("same_cycle_next", 64'h104, mk(1, 1, 64'h400, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    task automatic test_flush_clear;
        item_t x;
        // An idle update bus carrying clear=1 must leave the table alone.
        @(negedge clk);
        set_update(64'h104, 64'h0, 1'b0, 1'b0, 1'b1);
        bp.valid = 1'b0;
        @(posedge clk);
        #1;
        q.push_back(it("idle_bus_ignored", 64'h104, mk(1, 1, 64'h400, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        @(negedge clk);
        flush = 1'b1;
        set_update(64'h108, 64'h900, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0; bp.valid = 1'b0;
        q.push_back(it("flush_100", 64'h100, mk(0, 0, 0, 0)));
        q.push_back(it("flush_104", 64'h104, mk(0, 0, 0, 0)));
        q.push_back(it("flush_beats_update", 64'h108, mk(0, 0, 0, 0)));
        q.push_back(it("flush_10c", 64'h10C, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        apply_update(64'h104, 64'h500, 1'b1, 1'b1, 1'b0);
        q.push_back(it("retrain_after_flush", 64'h104, mk(1, 1, 64'h500, 1)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        apply_update(64'h104, 64'h600, 1'b1, 1'b1, 1'b1);
        q.push_back(it("clear_entry", 64'h104, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        // Cleared entry restarts as invalid: a not-taken update gives counter 01.
        apply_update(64'h104, 64'h0, 1'b0, 1'b0, 1'b0);
        q.push_back(it("after_clear_nt", 64'h104, mk(1, 0, 64'h500, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    task automatic test_async_reset;
        item_t x;
        apply_update(64'h110, 64'h700, 1'b1, 1'b1, 1'b0);
        q.push_back(it("pre_reset_valid", 64'h110, mk(1, 1, 64'h700, 1)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        @(negedge clk);
        set_update(64'h114, 64'h780, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        q.push_back(it("async_rst_immediate", 64'h110, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0; bp.valid = 1'b0;
        q.push_back(it("post_rst_110", 64'h110, mk(0, 0, 0, 0)));
        q.push_back(it("post_rst_aborted", 64'h114, mk(0, 0, 0, 0)));
        q.push_back(it("post_rst_100", 64'h100, mk(0, 0, 0, 0)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
        apply_update(64'h118, 64'hA00, 1'b0, 1'b1, 1'b0);
        q.push_back(it("post_rst_first_update", 64'h118, mk(1, 0, 64'h0, 1)));
        while (q.size() > 0) begin
            x = q.pop_front(); vpc = x.vpc; #1; checks++;
            if (sbe !== x.exp) begin
                errors++; $display("FAIL %s vpc=%h got=%h want=%h", x.tag, x.vpc, sbe, x.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_train_alias();
        test_not_taken();
        test_saturation();
        test_same_cycle();
        test_flush_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
